// File: rtl/des_byte_loader.sv
// des_byte_loader: assembles a 64-bit key then a 64-bit block from an MSB-first byte stream
// Latency: load 1 cycle after the 8th data accept; done RESULT_LATENCY cycles after load
// Backpressure: byte_ready low in LOAD/WAIT; a byte offered there stays pending, never dropped
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   byte_in/_valid/_ready 8-bit valid/ready byte stream, MSB-first within each 64-bit word
//   key_reuse             sampled in the done cycle: next block streams data bytes only
//   key_out, data_out     assembled key / block, wired to the core's key_in / data_in
//   load                  one-cycle pulse telling the core to capture key_out / data_out
//   busy                  high while the core is working (LOAD and WAIT)
//   done                  one-cycle pulse in the cycle the core's data_out is valid
//   parity_err            sticky: some byte of the current key had even parity
//
// RESULT_LATENCY is the core's load-to-result delay in cycles, legal range 1..255.

module des_byte_loader #(
   parameter int RESULT_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        key_reuse,
   output logic [63:0] key_out,
   output logic [63:0] data_out,
   output logic        load,
   output logic        busy,
   output logic        done,
   output logic        parity_err
);

   typedef enum logic [1:0] {
      ST_KEY  = 2'd0,
      ST_DATA = 2'd1,
      ST_LOAD = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   localparam logic [7:0] LATENCY = 8'(RESULT_LATENCY);

   state_t      state_q,     state_d;
   logic [2:0]  byte_cnt_q,  byte_cnt_d;
   logic [7:0]  wait_cnt_q,  wait_cnt_d;
   logic        key_valid_q, key_valid_d;
   logic [63:0] key_q,       key_d;
   logic [63:0] data_q,      data_d;
   logic        parity_q,    parity_d;
   logic        load_q,      load_d;
   logic        busy_q,      busy_d;
   logic        done_q,      done_d;

   logic        accept;
   logic        byte_bad;

   // Ready comes straight from registered state so it never depends on byte_valid.
   assign byte_ready = (state_q == ST_KEY) || (state_q == ST_DATA);
   assign accept     = byte_valid && byte_ready;

   // DES key bytes carry odd parity; an even number of ones flags the byte.
   assign byte_bad   = ~(^byte_in);

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      key_valid_d = key_valid_q;
      key_d       = key_q;
      data_d      = data_q;
      parity_d    = parity_q;

      case (state_q)
         ST_KEY: begin
            if (accept) begin
               key_d = {key_q[55:0], byte_in};
               // First byte of a fresh key restarts the sticky flag.
               if (byte_cnt_q == 3'd0) begin
                  parity_d = byte_bad;
               end else begin
                  parity_d = parity_q | byte_bad;
               end
               if (byte_cnt_q == 3'd7) begin
                  state_d     = ST_DATA;
                  key_valid_d = 1'b1;
                  byte_cnt_d  = 3'd0;
               end else begin
                  byte_cnt_d  = byte_cnt_q + 3'd1;
               end
            end
         end

         ST_DATA: begin
            if (accept) begin
               data_d = {data_q[55:0], byte_in};
               if (byte_cnt_q == 3'd7) begin
                  state_d    = ST_LOAD;
                  byte_cnt_d = 3'd0;
               end else begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
               end
            end
         end

         ST_LOAD: begin
            state_d    = ST_WAIT;
            wait_cnt_d = 8'd1;
         end

         ST_WAIT: begin
            if (wait_cnt_q == LATENCY) begin
               // Reuse is only honoured once a complete key has been captured since reset.
               state_d    = (key_reuse && key_valid_q) ? ST_DATA : ST_KEY;
               wait_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = ST_KEY;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state/count.
      load_d = (state_d == ST_LOAD);
      busy_d = (state_d == ST_LOAD) || (state_d == ST_WAIT);
      done_d = (state_d == ST_WAIT) && (wait_cnt_d == LATENCY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_KEY;
         byte_cnt_q  <= 3'd0;
         wait_cnt_q  <= 8'd0;
         key_valid_q <= 1'b0;
         key_q       <= 64'd0;
         data_q      <= 64'd0;
         parity_q    <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         key_valid_q <= key_valid_d;
         key_q       <= key_d;
         data_q      <= data_d;
         parity_q    <= parity_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign key_out    = key_q;
   assign data_out   = data_q;
   assign parity_err = parity_q;
   assign load       = load_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
